// File: rtl/sw_pkg.sv
// ============================================================================
//  Module      : sw_pkg
//  Description : Shared widths, wildcard code and saturating score helpers
//                for the affine-gap Smith-Waterman processing element.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sw_pkg;

  localparam int SCORE_W_DEF = 16;
  localparam int CHAR_W_DEF  = 2;
  localparam int COL_W_DEF   = 16;

  // Widest supported character code; the active code is the low CHAR_W bits.
  localparam int MAX_CHAR_W = 8;
  localparam logic [MAX_CHAR_W-1:0] WILDCARD_CODE = '1;

  // Scores are carried in a common wide signed type and narrowed at the edge.
  localparam int WIDE_W = 32;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic wide_t sat_add(wide_t a, wide_t b, int unsigned w);
    logic signed [WIDE_W:0] sum;
    logic signed [WIDE_W:0] hi;
    logic signed [WIDE_W:0] lo;
    sum = {a[WIDE_W-1], a} + {b[WIDE_W-1], b};
    hi = '0;
    hi[w-1] = 1'b1;
    hi = hi - 1;
    lo = ~hi;
    if (sum > hi) return wide_t'(hi);
    if (sum < lo) return wide_t'(lo);
    return wide_t'(sum);
  endfunction

  function automatic wide_t max2(wide_t a, wide_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic wide_t max4(wide_t a, wide_t b, wide_t c, wide_t d);
    return max2(max2(a, b), max2(c, d));
  endfunction

endpackage

`default_nettype wire

// File: rtl/sw_pe_affine_if.sv
// ============================================================================
//  Module      : sw_pe_affine_if
//  Description : Systolic, configuration and max-tracker signals of one PE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sw_pe_affine_if #(
  parameter int SCORE_W = 16,
  parameter int CHAR_W  = 2,
  parameter int COL_W   = 16
);
  logic                      enable;
  logic                      enableOut;
  logic                      newLineIn;
  logic                      newLineOut;
  logic                      sLoad;
  logic [CHAR_W-1:0]         sIn;
  logic [CHAR_W-1:0]         tIn;
  logic [CHAR_W-1:0]         tOut;
  logic signed [SCORE_W-1:0] vIn;
  logic signed [SCORE_W-1:0] vIn_alpha;
  logic signed [SCORE_W-1:0] fIn;
  logic signed [SCORE_W-1:0] vOut;
  logic signed [SCORE_W-1:0] vOut_alpha;
  logic signed [SCORE_W-1:0] fOut;
  logic signed [SCORE_W-1:0] minusAlpha;
  logic signed [SCORE_W-1:0] minusBeta;
  logic signed [SCORE_W-1:0] match;
  logic signed [SCORE_W-1:0] mismatch;
  logic                      clrMax;
  logic signed [SCORE_W-1:0] maxScore;
  logic [COL_W-1:0]          maxCol;

  modport master (
    output enable, newLineIn, sLoad, sIn, tIn, vIn, vIn_alpha, fIn,
           minusAlpha, minusBeta, match, mismatch, clrMax,
    input  enableOut, newLineOut, tOut, vOut, vOut_alpha, fOut, maxScore, maxCol
  );

  modport slave (
    input  enable, newLineIn, sLoad, sIn, tIn, vIn, vIn_alpha, fIn,
           minusAlpha, minusBeta, match, mismatch, clrMax,
    output enableOut, newLineOut, tOut, vOut, vOut_alpha, fOut, maxScore, maxCol
  );
endinterface

`default_nettype wire

// File: rtl/sw_max_track.sv
// ============================================================================
//  Module      : sw_max_track
//  Description : Column counter plus running best score and its column.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_max_track #(
  parameter int SCORE_W = 16,
  parameter int COL_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      newLine,
  input  logic                      clrMax,
  input  logic signed [SCORE_W-1:0] v,
  output logic signed [SCORE_W-1:0] maxScore,
  output logic [COL_W-1:0]          maxCol
);

  logic [COL_W-1:0]          r_col;
  logic [COL_W-1:0]          w_curCol;
  logic signed [SCORE_W-1:0] r_max;
  logic signed [SCORE_W-1:0] w_base;
  logic [COL_W-1:0]          r_maxCol;

  // A clear in the same cycle as a cell makes that cell compete against zero.
  always_comb begin
    w_curCol = newLine ? '0 : r_col;
    w_base   = clrMax ? '0 : r_max;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col    <= '0;
      r_max    <= '0;
      r_maxCol <= '0;
    end else begin
      if (enable) r_col <= w_curCol + COL_W'(1);
      if (enable && (v > w_base)) begin
        r_max    <= v;
        r_maxCol <= w_curCol;
      end else if (clrMax) begin
        r_max    <= '0;
        r_maxCol <= '0;
      end
    end
  end

  assign maxScore = r_max;
  assign maxCol   = r_maxCol;

endmodule

`default_nettype wire

// File: rtl/sw_pe_affine.sv
// ============================================================================
//  Module      : sw_pe_affine
//  Description : Affine-gap Smith-Waterman systolic PE with saturating scores.
//                Max tracker built only when SW_PE_MAXTRACK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_pe_affine
  import sw_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int CHAR_W  = CHAR_W_DEF,
  parameter int COL_W   = COL_W_DEF
) (
  input logic           clk,
  input logic           rst,
  sw_pe_affine_if.slave bus
);

  typedef logic signed [SCORE_W-1:0] score_t;
  localparam logic [CHAR_W-1:0] c_WILD = WILDCARD_CODE[CHAR_W-1:0];

  score_t            r_vOut, r_vOutAlpha, r_fOut, r_vDiag, r_preE;
  logic [CHAR_W-1:0] r_sReg, r_tOut;
  logic              r_enableOut, r_newLineOut;

  logic  w_isMatch;
  wide_t w_subst, w_diag, w_eExt, w_eOpen, w_e, w_f, w_v, w_vAlpha;

  function automatic wide_t widen(score_t x);
    return wide_t'(x);
  endfunction

  always_comb begin
    w_isMatch = (r_sReg == bus.tIn) && (r_sReg != c_WILD);
    w_subst   = w_isMatch ? widen(bus.match) : widen(bus.mismatch);
    w_diag    = sat_add(bus.newLineIn ? wide_t'(0) : widen(r_vDiag), w_subst, SCORE_W);
    w_eExt    = sat_add(bus.newLineIn ? wide_t'(0) : widen(r_preE), widen(bus.minusBeta), SCORE_W);
    w_eOpen   = bus.newLineIn ? widen(bus.minusAlpha) : widen(r_vOutAlpha);
    w_e       = max2(w_eExt, w_eOpen);
    w_f       = max2(widen(bus.vIn_alpha), sat_add(widen(bus.fIn), widen(bus.minusBeta), SCORE_W));
    w_v       = max4(w_diag, w_e, w_f, wide_t'(0));
    w_vAlpha  = sat_add(w_v, widen(bus.minusAlpha), SCORE_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vOut       <= '0;
      r_vOutAlpha  <= '0;
      r_fOut       <= '0;
      r_vDiag      <= '0;
      r_preE       <= '0;
      r_sReg       <= '0;
      r_tOut       <= '0;
      r_enableOut  <= 1'b0;
      r_newLineOut <= 1'b0;
    end else begin
      // The cell this cycle still scores against the previous sReg.
      if (bus.sLoad) r_sReg <= bus.sIn;
      r_enableOut  <= bus.enable;
      r_newLineOut <= bus.enable & bus.newLineIn;
      if (bus.enable) begin
        r_vOut      <= score_t'(w_v);
        r_vOutAlpha <= score_t'(w_vAlpha);
        r_fOut      <= score_t'(w_f);
        r_vDiag     <= bus.vIn;
        r_preE      <= score_t'(w_e);
        r_tOut      <= bus.tIn;
      end
    end
  end

  assign bus.vOut       = r_vOut;
  assign bus.vOut_alpha = r_vOutAlpha;
  assign bus.fOut       = r_fOut;
  assign bus.tOut       = r_tOut;
  assign bus.enableOut  = r_enableOut;
  assign bus.newLineOut = r_newLineOut;

`ifdef SW_PE_MAXTRACK_EN
  score_t           w_maxScore;
  logic [COL_W-1:0] w_maxCol;

  sw_max_track #(
    .SCORE_W (SCORE_W),
    .COL_W   (COL_W)
  ) u_maxTrack (
    .clk      (clk),
    .rst      (rst),
    .enable   (bus.enable),
    .newLine  (bus.newLineIn),
    .clrMax   (bus.clrMax),
    .v        (score_t'(w_v)),
    .maxScore (w_maxScore),
    .maxCol   (w_maxCol)
  );

  assign bus.maxScore = w_maxScore;
  assign bus.maxCol   = w_maxCol;
`else
  logic w_unusedClrMax;
  assign w_unusedClrMax = bus.clrMax;
  assign bus.maxScore   = '0;
  assign bus.maxCol     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sw_pe_affine.sv
// ============================================================================
//  Module      : tb_sw_pe_affine
//  Description : Directed bench for sw_pe_affine (16-bit and 8-bit scores).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sw_pe_affine;

`ifdef SW_PE_MAXTRACK_EN
  localparam bit c_TRK = 1'b1;
`else
  localparam bit c_TRK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   nAssert = 0;
  int   nFail   = 0;

  always #5 clk = ~clk;

  sw_pe_affine_if #(.SCORE_W(16), .CHAR_W(2), .COL_W(16)) a ();
  sw_pe_affine_if #(.SCORE_W(8),  .CHAR_W(2), .COL_W(16)) b ();

  sw_pe_affine #(.SCORE_W(16), .CHAR_W(2), .COL_W(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (a.slave)
  );

  sw_pe_affine #(.SCORE_W(8), .CHAR_W(2), .COL_W(16)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    nAssert++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkA(input string tag, input int v, input int va, input int f,
                        input int en, input int nl);
    check({tag, ".vOut"}, a.vOut, v);
    check({tag, ".vOut_alpha"}, a.vOut_alpha, va);
    check({tag, ".fOut"}, a.fOut, f);
    check({tag, ".enableOut"}, a.enableOut, en);
    check({tag, ".newLineOut"}, a.newLineOut, nl);
  endtask

  task automatic checkMax(input string tag, input int s, input int c);
    check({tag, ".maxScore"}, a.maxScore, c_TRK ? s : 0);
    check({tag, ".maxCol"}, a.maxCol, c_TRK ? c : 0);
  endtask

  task automatic randomiseInputs();
    a.enable = 1'b1; a.newLineIn = $urandom_range(0, 1); a.sLoad = 1'b1;
    a.sIn = 2'($urandom); a.tIn = 2'($urandom); a.clrMax = $urandom_range(0, 1);
    a.vIn = 16'($urandom); a.vIn_alpha = 16'($urandom); a.fIn = 16'($urandom);
    b.enable = 1'b1; b.sLoad = 1'b1; b.sIn = 2'($urandom); b.tIn = 2'($urandom);
    b.vIn = 8'($urandom); b.vIn_alpha = 8'($urandom); b.fIn = 8'($urandom);
  endtask

  int seqAlpha [4] = '{3, 5, 5, 2};
  int seqMax   [4] = '{3, 5, 5, 5};
  int seqCol   [4] = '{0, 1, 1, 1};

  initial begin
    a.match = 16'sd2;  a.mismatch = -16'sd1; a.minusAlpha = -16'sd3; a.minusBeta = -16'sd1;
    b.match = 8'sd100; b.mismatch = -8'sd1;  b.minusAlpha = -8'sd3;  b.minusBeta = -8'sd1;
    b.newLineIn = 1'b0; b.clrMax = 1'b0;
    rst = 1'b1;
    randomiseInputs();
    step();
    randomiseInputs();
    step();
    checkA("reset", 0, 0, 0, 0, 0);
    check("reset.tOut", a.tOut, 0);
    checkMax("reset", 0, 0);
    check("reset8.vOut", b.vOut, 0);
    check("reset8.enableOut", b.enableOut, 0);

    rst = 1'b0;
    a.enable = 1'b0; a.sLoad = 1'b0; a.clrMax = 1'b0; a.newLineIn = 1'b0;
    b.enable = 1'b0; b.sLoad = 1'b0;
    step();

    // First cell of a line
    a.enable = 1'b1; a.newLineIn = 1'b1; a.tIn = 2'd0;
    a.vIn = 16'sd0; a.vIn_alpha = -16'sd3; a.fIn = 16'sd0;
    step();
    checkA("first", 2, -1, -1, 1, 1);
    check("first.tOut", a.tOut, 0);
    checkMax("first", 2, 0);

    // Stall with garbage on the inputs
    a.enable = 1'b0; a.newLineIn = 1'b1; a.tIn = 2'd2; a.vIn = 16'sd77; a.fIn = 16'sd50;
    for (int i = 0; i < 3; i++) begin
      step();
      checkA("stall", 2, -1, -1, 0, 0);
      check("stall.tOut", a.tOut, 0);
    end

    a.enable = 1'b1; a.newLineIn = 1'b0; a.tIn = 2'd1;
    a.vIn = 16'sd4; a.vIn_alpha = 16'sd1; a.fIn = 16'sd0;
    step();
    checkA("afterStall", 1, -2, 1, 1, 0);
    check("afterStall.tOut", a.tOut, 1);
    checkMax("afterStall", 2, 0);

    // Load coincident with a cell: old sReg (0) matches tIn=0
    a.sLoad = 1'b1; a.sIn = 2'd1; a.tIn = 2'd0;
    a.vIn = 16'sd0; a.vIn_alpha = -16'sd3; a.fIn = -16'sd5;
    step();
    checkA("sLoadOld", 6, 3, -3, 1, 0);
    checkMax("sLoadOld", 6, 2);

    a.sLoad = 1'b0; a.tIn = 2'd1; a.fIn = 16'sd0;
    step();
    checkA("sLoadNew", 3, 0, -1, 1, 0);

    // Wildcard pair sReg=3, tIn=3 must score mismatch
    a.enable = 1'b0; a.sLoad = 1'b1; a.sIn = 2'd3;
    step();
    a.sLoad = 1'b0; a.enable = 1'b1; a.newLineIn = 1'b1; a.tIn = 2'd3;
    a.vIn = 16'sd0; a.vIn_alpha = -16'sd3; a.fIn = 16'sd0;
    step();
    checkA("wildcard", 0, -3, -1, 1, 1);
    checkMax("wildcard", 6, 2);

    a.enable = 1'b0; a.clrMax = 1'b1;
    step();
    a.clrMax = 1'b0;
    checkMax("clrIdle", 0, 0);

    // V sequence 3,5,5,2 driven through the F path (sReg is the wildcard)
    a.enable = 1'b1; a.tIn = 2'd0; a.vIn = 16'sd0; a.fIn = 16'sd0;
    for (int i = 0; i < 4; i++) begin
      a.newLineIn = (i == 0);
      a.vIn_alpha = 16'(seqAlpha[i]);
      step();
      check($sformatf("seq%0d.vOut", i), a.vOut, seqAlpha[i]);
      checkMax($sformatf("seq%0d", i), seqMax[i], seqCol[i]);
    end

    a.newLineIn = 1'b0; a.clrMax = 1'b1; a.vIn_alpha = 16'sd4;
    step();
    check("clrCell.vOut", a.vOut, 4);
    checkMax("clrCell", 4, 4);
    a.clrMax = 1'b0; a.enable = 1'b0;

    // Reset while a cell is in flight
    a.enable = 1'b1; a.vIn_alpha = 16'sd7; rst = 1'b1;
    step();
    rst = 1'b0; a.enable = 1'b0;
    checkA("midReset", 0, 0, 0, 0, 0);
    checkMax("midReset", 0, 0);

    // 8-bit saturation
    b.enable = 1'b1; b.newLineIn = 1'b1; b.tIn = 2'd0;
    b.vIn = 8'sd100; b.vIn_alpha = 8'sd0; b.fIn = 8'sd0;
    step();
    check("sat1.vOut", b.vOut, 100);
    check("sat1.vOut_alpha", b.vOut_alpha, 97);
    b.newLineIn = 1'b0; b.vIn = 8'sd0;
    step();
    check("satHi.vOut", b.vOut, 127);
    check("satHi.vOut_alpha", b.vOut_alpha, 124);
    b.tIn = 2'd1; b.vIn_alpha = -8'sd128; b.fIn = -8'sd128;
    step();
    check("satLo.fOut", b.fOut, -128);
    check("satLo.vOut", b.vOut, 124);
    b.enable = 1'b0;
    step();
    check("sat.enableOut", b.enableOut, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

`default_nettype wire
